// File: rtl/dm_access_if.sv
// Request/response bus between the core's load/store stage and the
// data-memory responder.
interface dm_access_if #(
   parameter int ADDR_W = 32
);
   logic              req_valid;
   logic              req_ready;
   logic              mem_write;
   logic [2:0]        dm_type;
   logic [ADDR_W-1:0] addr;
   logic [31:0]       wdata;
   logic              resp_valid;
   logic              resp_ready;
   logic [31:0]       rdata;
   logic              err;
   logic              busy;

   modport master (
      output req_valid, mem_write, dm_type, addr, wdata, resp_ready,
      input  req_ready, resp_valid, rdata, err, busy
   );

   modport slave (
      input  req_valid, mem_write, dm_type, addr, wdata, resp_ready,
      output req_ready, resp_valid, rdata, err, busy
   );
endinterface

// File: rtl/dm_access.sv
// Data-memory responder: one access at a time over a valid/ready bus.
// Owns a word-organised single-port RAM; sub-word stores are done as
// read-modify-write, loads are returned sign- or zero-extended.
module dm_access #(
   parameter int DEPTH  = 1024,
   parameter int ADDR_W = 32
) (
   input logic       clk,
   input logic       rstn,
   dm_access_if.slave bus
);
   localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_RD,
      ST_WR,
      ST_RESP
   } state_t;

   state_t            r_state;
   logic              r_req_ready;
   logic              r_resp_valid;
   logic              r_err;
   logic              r_busy;
   logic [31:0]       r_rdata;

   logic              r_mw;
   logic [2:0]        r_type;
   logic [1:0]        r_lane;
   logic [IDX_W-1:0]  r_idx;
   logic [31:0]       r_wdata;
   logic [31:0]       r_word;

   logic [31:0]       r_mem [DEPTH];

   logic [63:0]       w_addr_ext;
   logic              w_oob;
   logic              w_misal;
   logic              w_bad_type;
   logic              w_bad_store;
   logic              w_req_err;
   logic              w_fire;
   logic [31:0]       w_wr_word;

   // Pick the addressed lane(s) out of a little-endian word and extend.
   function automatic logic [31:0] f_extract(input logic [31:0] word,
                                              input logic [2:0]  dtype,
                                              input logic [1:0]  lane);
      logic [31:0] sh;
      sh = word >> {lane, 3'b000};
      case (dtype)
         3'b001:  f_extract = {{16{sh[15]}}, sh[15:0]};
         3'b010:  f_extract = {16'h0000, sh[15:0]};
         3'b011:  f_extract = {{24{sh[7]}}, sh[7:0]};
         3'b100:  f_extract = {24'h000000, sh[7:0]};
         default: f_extract = word;
      endcase
   endfunction

   // Overlay the store data on the previously read word for sub-word stores.
   function automatic logic [31:0] f_merge(input logic [31:0] word,
                                            input logic [31:0] data,
                                            input logic [2:0]  dtype,
                                            input logic [1:0]  lane);
      logic [31:0] mask;
      logic [31:0] rep;
      case (dtype)
         3'b001: begin
            mask = 32'h0000_FFFF << {lane[1], 4'b0000};
            rep  = {2{data[15:0]}};
            f_merge = (word & ~mask) | (rep & mask);
         end
         3'b011: begin
            mask = 32'h0000_00FF << {lane, 3'b000};
            rep  = {4{data[7:0]}};
            f_merge = (word & ~mask) | (rep & mask);
         end
         default: f_merge = data;
      endcase
   endfunction

   // Request legality checks, evaluated on the incoming bus signals.
   always_comb begin
      w_addr_ext  = 64'(bus.addr);
      w_oob       = w_addr_ext >= (64'(DEPTH) * 64'd4);
      w_bad_type  = bus.dm_type > 3'd4;
      w_bad_store = bus.mem_write && ((bus.dm_type == 3'b010) || (bus.dm_type == 3'b100));
      w_misal     = 1'b0;
      case (bus.dm_type)
         3'b000:         w_misal = bus.addr[1:0] != 2'b00;
         3'b001, 3'b010: w_misal = bus.addr[0];
         default:        w_misal = 1'b0;
      endcase
      w_req_err = w_oob || w_bad_type || w_bad_store || w_misal;
      w_fire    = bus.req_valid && r_req_ready;
   end

   // Word written back in WR: merged for sub-word stores, raw for word stores.
   always_comb begin
      w_wr_word = f_merge(r_word, r_wdata, r_type, r_lane);
   end

   // RAM write port; contents are deliberately not reset.
   always_ff @(posedge clk) begin
      if (r_state == ST_WR) begin
         r_mem[r_idx] <= w_wr_word;
      end
   end

   // Access sequencer with registered handshake and response outputs.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_state      <= ST_IDLE;
         r_req_ready  <= 1'b1;
         r_resp_valid <= 1'b0;
         r_err        <= 1'b0;
         r_busy       <= 1'b0;
         r_rdata      <= '0;
         r_mw         <= 1'b0;
         r_type       <= '0;
         r_lane       <= '0;
         r_idx        <= '0;
         r_wdata      <= '0;
         r_word       <= '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_fire) begin
                  r_mw        <= bus.mem_write;
                  r_type      <= bus.dm_type;
                  r_lane      <= bus.addr[1:0];
                  r_idx       <= bus.addr[IDX_W+1:2];
                  r_wdata     <= bus.wdata;
                  r_req_ready <= 1'b0;
                  r_busy      <= 1'b1;
                  if (w_req_err) begin
                     r_state      <= ST_RESP;
                     r_resp_valid <= 1'b1;
                     r_err        <= 1'b1;
                     r_rdata      <= '0;
                  end else if (bus.mem_write && (bus.dm_type == 3'b000)) begin
                     r_state <= ST_WR;
                  end else begin
                     r_state <= ST_RD;
                  end
               end
            end
            ST_RD: begin
               // The RAM word is captured here; loads extract straight from it
               // so the response is ready one cycle after the read.
               r_word <= r_mem[r_idx];
               if (r_mw) begin
                  r_state <= ST_WR;
               end else begin
                  r_state      <= ST_RESP;
                  r_resp_valid <= 1'b1;
                  r_err        <= 1'b0;
                  r_rdata      <= f_extract(r_mem[r_idx], r_type, r_lane);
               end
            end
            ST_WR: begin
               r_state      <= ST_RESP;
               r_resp_valid <= 1'b1;
               r_err        <= 1'b0;
               r_rdata      <= '0;
            end
            ST_RESP: begin
               if (bus.resp_ready) begin
                  r_state      <= ST_IDLE;
                  r_resp_valid <= 1'b0;
                  r_err        <= 1'b0;
                  r_rdata      <= '0;
                  r_req_ready  <= 1'b1;
                  r_busy       <= 1'b0;
               end
            end
            default: begin
               r_state     <= ST_IDLE;
               r_req_ready <= 1'b1;
               r_busy      <= 1'b0;
            end
         endcase
      end
   end

   assign bus.req_ready  = r_req_ready;
   assign bus.resp_valid = r_resp_valid;
   assign bus.rdata      = r_rdata;
   assign bus.err        = r_err;
   assign bus.busy       = r_busy;
endmodule

// File: tb/tb_dm_access.sv
// Self-checking bench for dm_access: directed vector table, randomized
// accesses against a byte-addressed reference memory, and hand-written
// back-pressure and mid-access reset sequences.
module tb_dm_access;
   localparam int DEPTH  = 64;
   localparam int ADDR_W = 32;
   localparam int NBYTES = DEPTH * 4;

   logic clk;
   logic rstn;

   dm_access_if #(.ADDR_W(ADDR_W)) bif ();

   dm_access #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
      .clk  (clk),
      .rstn (rstn),
      .bus  (bif)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;

   logic [7:0] ref_b [NBYTES];

   typedef struct {
      string       name;
      logic        mw;
      logic [2:0]  dt;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] exp_rdata;
      logic        exp_err;
      int          exp_lat;
   } vec_t;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   // Reference model: byte-addressed memory, access size from dm_type.
   task automatic model(input logic mw, input logic [2:0] dt, input logic [31:0] a,
                        input logic [31:0] wd, output logic [31:0] rd,
                        output logic e, output int lat);
      int sz;
      logic [31:0] v;
      sz = (dt == 3'd0) ? 4 : ((dt <= 3'd2) ? 2 : 1);
      e  = (dt > 3'd4) || (mw && (dt == 3'd2 || dt == 3'd4)) ||
           ((a & 32'(sz - 1)) != 0) || (a >= 32'(NBYTES));
      rd = '0;
      if (e) begin
         lat = 1;
      end else if (!mw) begin
         lat = 2;
         v = '0;
         for (int i = 0; i < sz; i++) v = v | (32'(ref_b[a + 32'(i)]) << (8 * i));
         if (dt == 3'd1 && v[15]) v = v | 32'hFFFF_0000;
         if (dt == 3'd3 && v[7])  v = v | 32'hFFFF_FF00;
         rd = v;
      end else begin
         lat = (sz == 4) ? 2 : 3;
         for (int i = 0; i < sz; i++) ref_b[a + 32'(i)] = 8'(wd >> (8 * i));
      end
   endtask

   // Single access with immediate response consumption; returns latency
   // measured in cycles from the accept edge to the first sampled resp_valid.
   task automatic do_access(input logic mw, input logic [2:0] dt, input logic [31:0] a,
                            input logic [31:0] wd, output logic [31:0] rd,
                            output logic e, output int lat);
      int n;
      @(negedge clk);
      bif.req_valid  = 1'b1;
      bif.mem_write  = mw;
      bif.dm_type    = dt;
      bif.addr       = a;
      bif.wdata      = wd;
      bif.resp_ready = 1'b0;
      n = 0;
      while (!bif.req_ready && n < 20) begin
         @(negedge clk);
         n++;
      end
      if (n >= 20) begin
         checks++;
         failures++;
         $display("FAIL req_ready_timeout: got 0 expected 1");
      end
      @(posedge clk);
      @(negedge clk);
      bif.req_valid = 1'b0;
      lat = 1;
      while (!bif.resp_valid && lat < 20) begin
         @(negedge clk);
         lat++;
      end
      rd = bif.rdata;
      e  = bif.err;
      bif.resp_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      bif.resp_ready = 1'b0;
   endtask

   vec_t vecs [$];

   initial begin
      logic [31:0] rd, erd, held;
      logic        e, ee;
      int          lat, elat;

      vecs = '{
         '{"st_w_10",      1'b1, 3'd0, 32'h10,  32'h1234_5678, 32'h0,         1'b0, 2},
         '{"ld_w_10",      1'b0, 3'd0, 32'h10,  32'h0,         32'h1234_5678, 1'b0, 2},
         '{"st_b_11",      1'b1, 3'd3, 32'h11,  32'hFFFF_FFAB, 32'h0,         1'b0, 3},
         '{"ld_w_merge_b", 1'b0, 3'd0, 32'h10,  32'h0,         32'h1234_AB78, 1'b0, 2},
         '{"ld_b_s_11",    1'b0, 3'd3, 32'h11,  32'h0,         32'hFFFF_FFAB, 1'b0, 2},
         '{"ld_b_u_11",    1'b0, 3'd4, 32'h11,  32'h0,         32'h0000_00AB, 1'b0, 2},
         '{"st_h_12",      1'b1, 3'd1, 32'h12,  32'h5555_BEEF, 32'h0,         1'b0, 3},
         '{"ld_w_merge_h", 1'b0, 3'd0, 32'h10,  32'h0,         32'hBEEF_AB78, 1'b0, 2},
         '{"ld_h_s_12",    1'b0, 3'd1, 32'h12,  32'h0,         32'hFFFF_BEEF, 1'b0, 2},
         '{"ld_h_u_12",    1'b0, 3'd2, 32'h12,  32'h0,         32'h0000_BEEF, 1'b0, 2},
         '{"ld_w_mis_13",  1'b0, 3'd0, 32'h13,  32'h0,         32'h0,         1'b1, 1},
         '{"st_h_mis_11",  1'b1, 3'd1, 32'h11,  32'h0000_1111, 32'h0,         1'b1, 1},
         '{"ld_w_after",   1'b0, 3'd0, 32'h10,  32'h0,         32'hBEEF_AB78, 1'b0, 2},
         '{"ld_w_oob",     1'b0, 3'd0, 32'h100, 32'h0,         32'h0,         1'b1, 1},
         '{"ld_type7",     1'b0, 3'd7, 32'h10,  32'h0,         32'h0,         1'b1, 1},
         '{"st_type_hu",   1'b1, 3'd2, 32'h10,  32'h0000_2222, 32'h0,         1'b1, 1},
         '{"st_w_last",    1'b1, 3'd0, 32'hFC,  32'hCAFE_F00D, 32'h0,         1'b0, 2},
         '{"ld_b_last",    1'b0, 3'd3, 32'hFF,  32'h0,         32'hFFFF_FFCA, 1'b0, 2},
         '{"ld_h_oob",     1'b0, 3'd1, 32'h102, 32'h0,         32'h0,         1'b1, 1}
      };

      rstn           = 1'b0;
      bif.req_valid  = 1'b0;
      bif.mem_write  = 1'b0;
      bif.dm_type    = '0;
      bif.addr       = '0;
      bif.wdata      = '0;
      bif.resp_ready = 1'b0;
      for (int i = 0; i < NBYTES; i++) ref_b[i] = '0;

      #12;
      check("rst_req_ready",  32'(bif.req_ready),  32'd1);
      check("rst_resp_valid", 32'(bif.resp_valid), 32'd0);
      check("rst_busy",       32'(bif.busy),       32'd0);
      check("rst_rdata",      bif.rdata,           32'd0);
      check("rst_err",        32'(bif.err),        32'd0);
      @(negedge clk);
      rstn = 1'b1;

      // Give every RAM word a defined value.
      for (int w = 0; w < DEPTH; w++) begin
         logic [31:0] v;
         v = $urandom;
         model(1'b1, 3'd0, 32'(w * 4), v, erd, ee, elat);
         do_access(1'b1, 3'd0, 32'(w * 4), v, rd, e, lat);
         check("init_err", 32'(e), 32'(ee));
         check("init_lat", 32'(lat), 32'(elat));
      end

      foreach (vecs[i]) begin
         model(vecs[i].mw, vecs[i].dt, vecs[i].addr, vecs[i].wdata, erd, ee, elat);
         do_access(vecs[i].mw, vecs[i].dt, vecs[i].addr, vecs[i].wdata, rd, e, lat);
         check({vecs[i].name, "_rdata"}, rd, vecs[i].exp_rdata);
         check({vecs[i].name, "_err"}, 32'(e), 32'(vecs[i].exp_err));
         check({vecs[i].name, "_lat"}, 32'(lat), 32'(vecs[i].exp_lat));
      end

      for (int k = 0; k < 300; k++) begin
         logic        mw;
         logic [2:0]  dt;
         logic [31:0] a, wd;
         int          sel;
         mw  = 1'($urandom_range(0, 1));
         dt  = 3'($urandom_range(0, 7));
         wd  = $urandom;
         sel = $urandom_range(0, 9);
         if (sel < 8)       a = 32'($urandom_range(0, 63));
         else if (sel == 8) a = 32'($urandom_range(252, 263));
         else               a = $urandom;
         model(mw, dt, a, wd, erd, ee, elat);
         do_access(mw, dt, a, wd, rd, e, lat);
         check("rnd_rdata", rd, erd);
         check("rnd_err", 32'(e), 32'(ee));
         check("rnd_lat", 32'(lat), 32'(elat));
      end

      // Back-pressure: response held for three extra cycles while another
      // request waits on the bus.
      model(1'b0, 3'd0, 32'h10, 32'h0, erd, ee, elat);
      @(negedge clk);
      bif.req_valid = 1'b1;
      bif.mem_write = 1'b0;
      bif.dm_type   = 3'd0;
      bif.addr      = 32'h10;
      @(posedge clk);
      @(negedge clk);
      bif.mem_write = 1'b1;
      bif.addr      = 32'h20;
      bif.wdata     = 32'hDEAD_BEEF;
      @(negedge clk);
      check("bp_resp_valid", 32'(bif.resp_valid), 32'd1);
      check("bp_rdata", bif.rdata, erd);
      held = bif.rdata;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         check("bp_hold_valid", 32'(bif.resp_valid), 32'd1);
         check("bp_hold_rdata", bif.rdata, held);
         check("bp_hold_err",   32'(bif.err), 32'd0);
         check("bp_req_ready",  32'(bif.req_ready), 32'd0);
         check("bp_busy",       32'(bif.busy), 32'd1);
      end
      bif.req_valid  = 1'b0;
      bif.resp_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      bif.resp_ready = 1'b0;
      check("bp_after_valid", 32'(bif.resp_valid), 32'd0);
      check("bp_after_rdata", bif.rdata, 32'd0);
      check("bp_after_ready", 32'(bif.req_ready), 32'd1);
      model(1'b0, 3'd0, 32'h20, 32'h0, erd, ee, elat);
      do_access(1'b0, 3'd0, 32'h20, 32'h0, rd, e, lat);
      check("bp_ignored_store", rd, erd);

      // Reset while a byte store is in its read phase.
      model(1'b0, 3'd0, 32'h20, 32'h0, erd, ee, elat);
      @(negedge clk);
      bif.req_valid = 1'b1;
      bif.mem_write = 1'b1;
      bif.dm_type   = 3'd3;
      bif.addr      = 32'h21;
      bif.wdata     = {24'h0, ~erd[15:8]};
      @(posedge clk);
      #2;
      rstn          = 1'b0;
      bif.req_valid = 1'b0;
      #1;
      check("mrst_busy",       32'(bif.busy), 32'd0);
      check("mrst_resp_valid", 32'(bif.resp_valid), 32'd0);
      check("mrst_req_ready",  32'(bif.req_ready), 32'd1);
      check("mrst_rdata",      bif.rdata, 32'd0);
      check("mrst_err",        32'(bif.err), 32'd0);
      @(posedge clk);
      @(posedge clk);
      @(negedge clk);
      rstn = 1'b1;
      do_access(1'b0, 3'd0, 32'h20, 32'h0, rd, e, lat);
      check("mrst_word_kept", rd, erd);
      check("mrst_load_err",  32'(e), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1);
   end
endmodule
